sobel_frame_ctrl: RTL and testbench
===================================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter IMG_HDISP, 11'd640, active pixels per line expected.
REQ-002 Parameter IMG_VDISP, 11'd480, active lines per frame expected.
REQ-003 clk  input  1  video pixel clock; sole clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cfg_wr  input  1  one-cycle config write strobe.
REQ-006 cfg_threshold  input  8  requested Sobel threshold, sampled on cfg_wr.
REQ-007 cfg_enable  input  1  level; 1 = run frames, 0 = stop at next frame boundary.
REQ-008 cfg_ack  output  1  one-cycle pulse acknowledging cfg_wr.
REQ-009 per_frame_vsync  input  1  frame-valid level (high during frame).
REQ-010 per_frame_href  input  1  line-valid level (high during active pixels).
REQ-011 post_img_Bit  input  1  edge flag returned by the Sobel detector, qualified by href.
REQ-012 Sobel_Threshold  output  8  active threshold driven to the detector.
REQ-013 frame_active  output  1  high while FSM is in FRAME state.
REQ-014 hcnt  output  11  pixel index within current line.
REQ-015 vcnt  output  11  line index within current frame.
REQ-016 frame_done  output  1  one-cycle pulse at end of each processed frame.
REQ-017 frame_err  output  1  one-cycle pulse with frame_done when geometry mismatched.
REQ-018 edge_count  output  20  edge pixels of last completed frame.
REQ-019 frame_cnt  output  16  processed-frame counter.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_SOF, FRAME, EOF.
REQ-021 IDLE -> WAIT_SOF when cfg_enable=1; WAIT_SOF -> IDLE when cfg_enable=0.
REQ-022 WAIT_SOF -> FRAME on vsync rising edge (vsync=1, registered vsync=0); a frame already in progress at enable SHALL be skipped.
REQ-023 FRAME -> EOF on vsync falling edge; EOF lasts exactly one cycle, then -> WAIT_SOF if cfg_enable=1 else IDLE.
REQ-024 cfg_wr SHALL load a pending register and pulse cfg_ack the next cycle, in any state; a later cfg_wr before frame start overwrites the pending value.
REQ-025 Sobel_Threshold SHALL update from pending only on the WAIT_SOF->FRAME transition; never mid-frame.
REQ-026 cfg_wr coincident with SOF: the value SHALL take effect at the following frame; the current frame uses the prior pending value.
REQ-027 hcnt SHALL increment each href-high cycle in FRAME, clear on href falling edge; saturate at 2047.
REQ-028 vcnt SHALL increment on each href falling edge in FRAME, clear on SOF; saturate at 2047.
REQ-029 Line error: href falling with hcnt+1 != IMG_HDISP SHALL set sticky per-frame err flag.
REQ-030 Frame error: at EOF vcnt != IMG_VDISP, or href still high at vsync fall, SHALL set err flag.
REQ-031 edge accumulator SHALL add 1 per cycle with href=1 and post_img_Bit=1 in FRAME, saturate at 20'hFFFFF, clear on SOF.
REQ-032 In EOF: frame_done=1, frame_err=err flag, edge_count<=accumulator, frame_cnt<=frame_cnt+1 (wraps at 16'hFFFF->0).
REQ-033 cfg_enable deassert in FRAME SHALL NOT abort the frame; completes through EOF.
REQ-034 All outputs SHALL be registered; counters lag inputs by one cycle.

Reset
REQ-035 rst_n low SHALL asynchronously force state IDLE, Sobel_Threshold=0, pending=0, all counters, edge_count, frame_cnt, and all pulses to 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame; after release, processing starts only at the next vsync rising edge with cfg_enable=1.

Structure
REQ-037 FSM state encoding and default IMG_HDISP/IMG_VDISP constants SHALL reside in shared package sobel_pkg.
REQ-038 One sub-module, sobel_geom_cnt (hcnt/vcnt, saturation, line-error detection), SHALL be instantiated; the rest stays flat.

Verification
REQ-039 cfg_wr threshold=8'd40 in IDLE, enable, one 640x480 frame -> cfg_ack next cycle, Sobel_Threshold=40 from SOF, frame_done once, frame_err=0, frame_cnt=1.
REQ-040 cfg_wr 8'd60 mid-frame -> Sobel_Threshold stays 40 until next SOF, then 60.
REQ-041 Frame with line 100 of 639 pixels -> frame_err=1 with frame_done; next correct frame -> frame_err=0.
REQ-042 post_img_Bit high on 1000 active pixels -> edge_count=1000 after EOF; cleared at next SOF.
REQ-043 Enable while vsync already high -> that frame ignored (no frame_done); next frame processed.
REQ-044 rst_n low at line 200 -> all outputs 0 immediately; partial frame produces no frame_done; frame_cnt preload 16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller.
// Holds the controller FSM encoding, the default frame geometry, the counter
// saturation limits and a saturating increment helper for the geometry
// counters.
package sobel_pkg;

    localparam logic [10:0] IMG_HDISP_DEF = 11'd640;
    localparam logic [10:0] IMG_VDISP_DEF = 11'd480;

    localparam logic [10:0] GEOM_CNT_MAX = 11'd2047;
    localparam logic [19:0] EDGE_CNT_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitSof = 2'd1,
        StFrame   = 2'd2,
        StEof     = 2'd3
    } sobel_state_e;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == GEOM_CNT_MAX) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/sobel_geom_cnt.sv
// Pixel / line geometry counters for the Sobel frame controller.
// hcnt holds the index of the pixel sampled at the previous clock edge: it
// advances on every href-high cycle that follows another href-high cycle, so
// the first pixel of a line reads as index 0. On the href falling edge hcnt+1
// is therefore the length of the line just finished; a length other than
// IMG_HDISP raises o_line_err for that cycle. vcnt counts completed lines.
// Both counters saturate at 2047 and only move while i_run is high.
//
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   i_clr         start of frame: clear both counters
//   i_run         controller is in its FRAME state
//   i_href        line-valid input
//   i_href_q      line-valid registered by one cycle
//   o_hcnt        pixel index within the current line
//   o_vcnt        line index within the current frame
//   o_line_err    one-cycle flag: line ended with wrong pixel count
module sobel_geom_cnt
    import sobel_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = IMG_HDISP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_run,
    input  logic        i_href,
    input  logic        i_href_q,
    output logic [10:0] o_hcnt,
    output logic [10:0] o_vcnt,
    output logic        o_line_err
);

    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic [10:0] w_hcnt_nxt;
    logic [10:0] w_vcnt_nxt;
    logic        w_href_fall;
    logic [11:0] w_line_len;

    assign w_href_fall = i_run & i_href_q & ~i_href;
    assign w_line_len  = {1'b0, r_hcnt} + 12'd1;
    assign o_line_err  = w_href_fall & (w_line_len != {1'b0, IMG_HDISP});

    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_vcnt_nxt = r_vcnt;
        if (i_clr) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = '0;
        end else if (i_run) begin
            if (w_href_fall) begin
                w_hcnt_nxt = '0;
                w_vcnt_nxt = sat_inc11(r_vcnt);
            end else if (i_href && i_href_q) begin
                w_hcnt_nxt = sat_inc11(r_hcnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
        end
    end

    assign o_hcnt = r_hcnt;
    assign o_vcnt = r_vcnt;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller wrapped around a Sobel edge detector.
// Accepts a threshold through a one-cycle config write, applies it to the
// detector only at a frame start, tracks frame geometry, counts edge pixels
// and reports per-frame completion, geometry errors and a frame counter.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   cfg_wr              config write strobe, cfg_threshold sampled with it
//   cfg_enable          run frames while high; stops at a frame boundary
//   cfg_ack             one-cycle acknowledge, cycle after cfg_wr
//   per_frame_vsync     frame-valid level
//   per_frame_href      line-valid level
//   post_img_Bit        edge flag from the detector, qualified by href
//   Sobel_Threshold     threshold currently driven to the detector
//   frame_active        high while in FRAME
//   hcnt, vcnt          pixel / line position within the frame
//   frame_done          one-cycle pulse after each processed frame
//   frame_err           geometry error, pulses together with frame_done
//   edge_count          edge pixels of the last completed frame
//   frame_cnt           processed-frame counter (wraps)
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = IMG_HDISP_DEF,
    parameter logic [10:0] IMG_VDISP = IMG_VDISP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr,
    input  logic [7:0]  cfg_threshold,
    input  logic        cfg_enable,
    output logic        cfg_ack,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        post_img_Bit,
    output logic [7:0]  Sobel_Threshold,
    output logic        frame_active,
    output logic [10:0] hcnt,
    output logic [10:0] vcnt,
    output logic        frame_done,
    output logic        frame_err,
    output logic [19:0] edge_count,
    output logic [15:0] frame_cnt
);

    sobel_state_e r_state;
    sobel_state_e w_state_nxt;

    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_pending;
    logic        r_cfg_ack;
    logic [7:0]  r_threshold;
    logic        r_err;
    logic [19:0] r_edge_acc;
    logic        r_frame_active;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [19:0] r_edge_count;
    logic [15:0] r_frame_cnt;

    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_sof;
    logic        w_in_frame;
    logic        w_in_eof;
    logic        w_line_err;
    logic [10:0] w_vcnt;
    logic        w_frame_active_nxt;
    logic        w_frame_done_nxt;
    logic        w_frame_err_nxt;
    logic [15:0] w_frame_cnt_nxt;

    assign w_vs_rise  = per_frame_vsync & ~r_vsync;
    assign w_vs_fall  = ~per_frame_vsync & r_vsync;
    assign w_in_frame = (r_state == StFrame);
    assign w_in_eof   = (r_state == StEof);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A frame already running when WAIT_SOF is entered never
    // shows a rising vsync edge, so it is skipped naturally.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (cfg_enable) w_state_nxt = StWaitSof;
            end
            StWaitSof: begin
                if (!cfg_enable)    w_state_nxt = StIdle;
                else if (w_vs_rise) w_state_nxt = StFrame;
            end
            StFrame: begin
                // cfg_enable is deliberately ignored: a started frame always completes
                if (w_vs_fall) w_state_nxt = StEof;
            end
            StEof: begin
                w_state_nxt = cfg_enable ? StWaitSof : StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Output / next-value logic
    always_comb begin
        w_sof              = (r_state == StWaitSof) && (w_state_nxt == StFrame);
        w_frame_active_nxt = (w_state_nxt == StFrame);
        w_frame_done_nxt   = w_in_eof;
        w_frame_err_nxt    = w_in_eof & (r_err | (w_vcnt != IMG_VDISP));
        w_frame_cnt_nxt    = r_frame_cnt;
        if (w_in_eof) w_frame_cnt_nxt = r_frame_cnt + 16'd1;
    end

    sobel_geom_cnt #(
        .IMG_HDISP (IMG_HDISP)
    ) u_geom (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_sof),
        .i_run      (w_in_frame),
        .i_href     (per_frame_href),
        .i_href_q   (r_href),
        .o_hcnt     (hcnt),
        .o_vcnt     (w_vcnt),
        .o_line_err (w_line_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync        <= 1'b0;
            r_href         <= 1'b0;
            r_pending      <= '0;
            r_cfg_ack      <= 1'b0;
            r_threshold    <= '0;
            r_err          <= 1'b0;
            r_edge_acc     <= '0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_err    <= 1'b0;
            r_edge_count   <= '0;
            r_frame_cnt    <= '0;
        end else begin
            r_vsync        <= per_frame_vsync;
            r_href         <= per_frame_href;
            r_cfg_ack      <= cfg_wr;
            r_frame_active <= w_frame_active_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_frame_err    <= w_frame_err_nxt;
            r_frame_cnt    <= w_frame_cnt_nxt;

            if (cfg_wr) r_pending <= cfg_threshold;
            // Non-blocking read: a write coinciding with SOF lands one frame later
            if (w_sof) r_threshold <= r_pending;

            if (w_sof) begin
                r_err <= 1'b0;
            end else if (w_in_frame && (w_line_err || (w_vs_fall && per_frame_href))) begin
                r_err <= 1'b1;
            end

            if (w_sof) begin
                r_edge_acc <= '0;
            end else if (w_in_frame && per_frame_href && post_img_Bit &&
                         (r_edge_acc != EDGE_CNT_MAX)) begin
                r_edge_acc <= r_edge_acc + 20'd1;
            end

            if (w_in_eof) r_edge_count <= r_edge_acc;
        end
    end

    assign cfg_ack         = r_cfg_ack;
    assign Sobel_Threshold = r_threshold;
    assign frame_active    = r_frame_active;
    assign vcnt            = w_vcnt;
    assign frame_done      = r_frame_done;
    assign frame_err       = r_frame_err;
    assign edge_count      = r_edge_count;
    assign frame_cnt       = r_frame_cnt;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed self-checking bench for sobel_frame_ctrl.
// The DUT runs with a reduced 40x30 geometry so full frames stay short.
module tb_sobel_frame_ctrl;

    localparam int HN = 40;
    localparam int VN = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [7:0]  cfg_threshold;
    logic        cfg_enable;
    logic        cfg_ack;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        post_img_Bit;
    logic [7:0]  Sobel_Threshold;
    logic        frame_active;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        frame_done;
    logic        frame_err;
    logic [19:0] edge_count;
    logic [15:0] frame_cnt;

    int   n_checks;
    int   n_fails;
    int   done_cnt = 0;
    logic last_err = 1'b0;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .IMG_HDISP (11'd40),
        .IMG_VDISP (11'd30)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr          (cfg_wr),
        .cfg_threshold   (cfg_threshold),
        .cfg_enable      (cfg_enable),
        .cfg_ack         (cfg_ack),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .post_img_Bit    (post_img_Bit),
        .Sobel_Threshold (Sobel_Threshold),
        .frame_active    (frame_active),
        .hcnt            (hcnt),
        .vcnt            (vcnt),
        .frame_done      (frame_done),
        .frame_err       (frame_err),
        .edge_count      (edge_count),
        .frame_cnt       (frame_cnt)
    );

    // Record every frame_done pulse and the error flag travelling with it
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_err = frame_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] thr);
        cfg_wr        = 1'b1;
        cfg_threshold = thr;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_eq("cfg_ack_pulse", 32'(cfg_ack), 1);
        @(negedge clk);
        check_eq("cfg_ack_clear", 32'(cfg_ack), 0);
    endtask

    task automatic sof();
        per_frame_vsync = 1'b1;
        @(negedge clk);
    endtask

    // nlines lines; line short_ln carries one pixel too few; the first
    // n_edge active pixels of the call have post_img_Bit set
    task automatic body(input int nlines, input int short_ln, input int n_edge);
        int pix;
        pix = 0;
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_ln) ? HN - 1 : HN;
            for (int p = 0; p < len; p++) begin
                per_frame_href = 1'b1;
                post_img_Bit   = (pix < n_edge) ? 1'b1 : 1'b0;
                pix++;
                @(negedge clk);
            end
            per_frame_href = 1'b0;
            post_img_Bit   = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic eof();
        per_frame_href  = 1'b0;
        per_frame_vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        rst_n           = 1'b0;
        cfg_wr          = 1'b0;
        cfg_threshold   = 8'd0;
        cfg_enable      = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        post_img_Bit    = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_thr",    32'(Sobel_Threshold), 0);
        check_eq("rst_active", 32'(frame_active), 0);
        check_eq("rst_hcnt",   32'(hcnt), 0);
        check_eq("rst_vcnt",   32'(vcnt), 0);
        check_eq("rst_done",   32'(frame_done), 0);
        check_eq("rst_err",    32'(frame_err), 0);
        check_eq("rst_edges",  32'(edge_count), 0);
        check_eq("rst_fcnt",   32'(frame_cnt), 0);
        check_eq("rst_ack",    32'(cfg_ack), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Threshold 40 written in IDLE, one good frame with 1000 edge pixels
        cfg_write(8'd40);
        check_eq("thr_not_yet", 32'(Sobel_Threshold), 0);
        cfg_enable = 1'b1;
        repeat (3) @(negedge clk);
        sof();
        check_eq("f1_thr_at_sof", 32'(Sobel_Threshold), 40);
        check_eq("f1_active", 32'(frame_active), 1);
        body(VN, -1, 1000);
        eof();
        check_eq("f1_done_cnt", 32'(done_cnt), 1);
        check_eq("f1_err", 32'(last_err), 0);
        check_eq("f1_fcnt", 32'(frame_cnt), 1);
        check_eq("f1_edges", 32'(edge_count), 1000);
        check_eq("f1_inactive", 32'(frame_active), 0);

        // Mid-frame write of 60 must not touch the running frame
        sof();
        check_eq("f2_thr", 32'(Sobel_Threshold), 40);
        body(15, -1, 7);
        cfg_write(8'd60);
        check_eq("f2_thr_mid", 32'(Sobel_Threshold), 40);
        body(15, -1, 0);
        eof();
        check_eq("f2_done_cnt", 32'(done_cnt), 2);
        check_eq("f2_err", 32'(last_err), 0);
        check_eq("f2_edges_cleared", 32'(edge_count), 7);
        check_eq("f2_thr_after", 32'(Sobel_Threshold), 40);

        // Line 3 one pixel short
        sof();
        check_eq("f3_thr_new", 32'(Sobel_Threshold), 60);
        body(VN, 3, 0);
        eof();
        check_eq("f3_done_cnt", 32'(done_cnt), 3);
        check_eq("f3_line_err", 32'(last_err), 1);

        // Good frame clears the error
        sof();
        body(VN, -1, 0);
        eof();
        check_eq("f4_done_cnt", 32'(done_cnt), 4);
        check_eq("f4_err", 32'(last_err), 0);
        check_eq("f4_fcnt", 32'(frame_cnt), 4);

        // One line missing
        sof();
        body(VN - 1, -1, 0);
        eof();
        check_eq("f5_done_cnt", 32'(done_cnt), 5);
        check_eq("f5_vcnt_err", 32'(last_err), 1);

        // Write coincident with SOF takes effect one frame later
        cfg_write(8'd77);
        per_frame_vsync = 1'b1;
        cfg_wr          = 1'b1;
        cfg_threshold   = 8'd99;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_eq("f6_thr_prior", 32'(Sobel_Threshold), 77);
        check_eq("f6_ack", 32'(cfg_ack), 1);
        body(VN, -1, 0);
        eof();
        check_eq("f6_done_cnt", 32'(done_cnt), 6);
        sof();
        check_eq("f7_thr_late", 32'(Sobel_Threshold), 99);
        body(VN, -1, 0);
        eof();
        check_eq("f7_done_cnt", 32'(done_cnt), 7);

        // Enable while a frame is already running: that frame is skipped
        cfg_enable = 1'b0;
        repeat (3) @(negedge clk);
        per_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
        cfg_enable = 1'b1;
        body(VN, -1, 0);
        check_eq("skip_inactive", 32'(frame_active), 0);
        eof();
        check_eq("skip_no_done", 32'(done_cnt), 7);

        // Disable mid-frame: frame still completes, then controller idles
        sof();
        check_eq("f8_active", 32'(frame_active), 1);
        body(10, -1, 0);
        cfg_enable = 1'b0;
        body(20, -1, 0);
        eof();
        check_eq("f8_done_cnt", 32'(done_cnt), 8);
        check_eq("f8_fcnt", 32'(frame_cnt), 8);
        sof();
        check_eq("idle_no_frame", 32'(frame_active), 0);
        body(2, -1, 0);
        eof();
        check_eq("idle_no_done", 32'(done_cnt), 8);
        cfg_enable = 1'b1;
        repeat (2) @(negedge clk);

        // Frame counter wrap from 16'hFFFF
        force dut.r_frame_cnt = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        check_eq("preload_fcnt", 32'(frame_cnt), 32'hFFFF);
        sof();
        body(VN, -1, 5);
        eof();
        check_eq("wrap_done_cnt", 32'(done_cnt), 9);
        check_eq("wrap_fcnt", 32'(frame_cnt), 0);
        check_eq("wrap_edges", 32'(edge_count), 5);

        // Reset in the middle of line 20
        sof();
        body(20, -1, 0);
        for (int p = 0; p < 10; p++) begin
            per_frame_href = 1'b1;
            @(negedge clk);
        end
        check_eq("pre_rst_vcnt", 32'(vcnt), 20);
        check_eq("pre_rst_hcnt", 32'(hcnt), 9);
        check_eq("pre_rst_active", 32'(frame_active), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_thr",    32'(Sobel_Threshold), 0);
        check_eq("mid_rst_active", 32'(frame_active), 0);
        check_eq("mid_rst_hcnt",   32'(hcnt), 0);
        check_eq("mid_rst_vcnt",   32'(vcnt), 0);
        check_eq("mid_rst_edges",  32'(edge_count), 0);
        check_eq("mid_rst_fcnt",   32'(frame_cnt), 0);
        check_eq("mid_rst_done",   32'(frame_done), 0);
        check_eq("mid_rst_err",    32'(frame_err), 0);
        check_eq("mid_rst_ack",    32'(cfg_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < HN - 11; p++) begin
            per_frame_href = 1'b1;
            @(negedge clk);
        end
        per_frame_href = 1'b0;
        repeat (4) @(negedge clk);
        body(VN - 21, -1, 0);
        check_eq("partial_inactive", 32'(frame_active), 0);
        eof();
        check_eq("partial_no_done", 32'(done_cnt), 9);

        // First full frame after reset is processed with the cleared threshold
        sof();
        check_eq("post_rst_thr", 32'(Sobel_Threshold), 0);
        check_eq("post_rst_active", 32'(frame_active), 1);
        body(VN, -1, 0);
        eof();
        check_eq("post_rst_done_cnt", 32'(done_cnt), 10);
        check_eq("post_rst_err", 32'(last_err), 0);
        check_eq("post_rst_fcnt", 32'(frame_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
